// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg
//   Shared types for the round-robin memory arbiter.
//   - lc3b_word / lc3b_line : default address and line types of the LC-3b
//                             memory hierarchy (sizes become parameter defaults)
//   - arb_state_t           : arbiter FSM encoding
package mem_arbiter_rr_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int LC3B_WORD_W = $bits(lc3b_word);
    localparam int LC3B_LINE_W = $bits(lc3b_line);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// mem_arbiter_rr_pick (rr_pick)
//   Combinational round-robin selector: finds the first set bit of `pending`
//   scanning upward from `rr_ptr`, wrapping modulo N.
// Ports:
//   pending [N-1:0] in  : one bit per requesting client
//   rr_ptr  [W-1:0] in  : highest-priority client index (must be < N)
//   any             out : at least one client is pending
//   pick    [W-1:0] out : selected client index (equals rr_ptr when !any)
module mem_arbiter_rr_pick
    import mem_arbiter_rr_pkg::*;
#(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] rr_ptr,
    output logic         any,
    output logic [W-1:0] pick
);

    localparam logic [W:0] N_VAL = (W+1)'(N);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    always_comb begin
        // Rotate so that client rr_ptr lands at bit 0. Doubling the vector
        // makes the wrap-around fall out of a plain right shift.
        doubled = {pending, pending};
        shifted = doubled >> rr_ptr;
        rotated = shifted[N-1:0];

        // Lowest set bit of the rotated vector wins.
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end

        // Un-rotate: (offset + rr_ptr) mod N, with one spare bit for the carry.
        sum = {1'b0, offset} + {1'b0, rr_ptr};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end

        any  = |pending;
        pick = sum[W-1:0];
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter sharing one physical-memory port among NUM_CLIENTS
//   cache-side requesters. A grant is registered and held for the whole
//   memory transaction; completion is routed back to the granted client.
//
// Handshake: each client raises req_read or req_write (level) and holds it,
//   with stable req_addr/req_wdata, until it sees its req_resp bit pulse for
//   one cycle; it must drop the request by the following cycle or it will be
//   granted again. On the memory side pmem_read/pmem_write stay high until
//   memory returns a single-cycle pmem_resp; a transaction is never aborted,
//   even if the client withdraws its request while granted.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_read/req_write [N]  : per-client line read / write requests
//   req_addr  [N*AW]        : packed addresses, client i at [i*AW +: AW]
//   req_wdata [N*LW]        : packed write lines, same packing
//   req_resp  [N]           : one-hot completion pulse to the granted client
//   req_rdata [LW]          : read line, valid only alongside req_resp
//   pmem_*                  : physical-memory port
//   grant_valid, grant_id   : FSM state (busy) and current grant, for debug
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_WIDTH  = LC3B_WORD_W,
    parameter int LINE_WIDTH  = LC3B_LINE_W,
    parameter int CLIENT_ID_W = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CLIENTS-1:0]            req_read,
    input  logic [NUM_CLIENTS-1:0]            req_write,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            req_resp,
    output logic [LINE_WIDTH-1:0]             req_rdata,
    output logic                              pmem_read,
    output logic                              pmem_write,
    output logic [ADDR_WIDTH-1:0]             pmem_address,
    output logic [LINE_WIDTH-1:0]             pmem_wdata,
    input  logic [LINE_WIDTH-1:0]             pmem_rdata,
    input  logic                              pmem_resp,
    output logic                              grant_valid,
    output logic [CLIENT_ID_W-1:0]            grant_id
);

    localparam logic [CLIENT_ID_W-1:0] LAST_ID = CLIENT_ID_W'(NUM_CLIENTS - 1);

    arb_state_t                state;
    logic [CLIENT_ID_W-1:0]    rr_ptr;
    logic [NUM_CLIENTS-1:0]    pending;
    logic                      pick_any;
    logic [CLIENT_ID_W-1:0]    pick;
    logic                      pick_write;
    logic                      busy;
    logic                      resp_fire;

    assign pending    = req_read | req_write;
    // A client raising both read and write is illegal; read takes precedence.
    assign pick_write = req_write[pick] & ~req_read[pick];
    assign busy       = (state == ARB_BUSY);
    assign resp_fire  = busy & pmem_resp;

    mem_arbiter_rr_pick #(
        .N (NUM_CLIENTS),
        .W (CLIENT_ID_W)
    ) u_rr_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .any     (pick_any),
        .pick    (pick)
    );

    // pmem_write doubles as the latched op_is_write flag for the transaction;
    // pmem_read is its complement while busy and zero while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id    <= pick;
                        pmem_read   <= ~pick_write;
                        pmem_write  <= pick_write;
                        grant_valid <= 1'b1;
                        state       <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (pmem_resp) begin
                        pmem_read   <= 1'b0;
                        pmem_write  <= 1'b0;
                        grant_valid <= 1'b0;
                        rr_ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        state       <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Data paths follow the held grant; everything reads zero while idle so
    // nothing stale leaks onto the memory bus or back to the clients.
    always_comb begin
        req_resp     = '0;
        req_rdata    = '0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (resp_fire) begin
            req_resp[grant_id] = 1'b1;
            req_rdata          = pmem_rdata;
        end
        if (busy) begin
            pmem_address = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            pmem_wdata   = req_wdata[grant_id*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    a_no_read_write_conflict: assert property (
        @(posedge clk) disable iff (!reset_n) (req_read & req_write) == '0
    );

endmodule
